cpu_ctrl: RTL

CPU_CTRL -- requirements
Module: cpu_ctrl

---
 rtl/cpu_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: sequencing controller for a small load/execute/store machine.
// Each instruction is sequenced as FETCH -> DECODE -> READ -> EXEC -> WRITE.
// A run covers PROG_LEN instructions and then parks in HALT until restarted.
// All outputs are flops loaded from the next-state values, so each output
// changes only on a clock edge and depends only on state and datapath
// registers.
module cpu_ctrl #(
  parameter int PC_W     = 4,
  parameter int PROG_LEN = 16   // legal range 1 .. 2**PC_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [7:0]      inst,
  input  logic            inst_valid,
  input  logic            wr_ready,
  output logic [PC_W-1:0] pc,
  output logic            inst_req,
  output logic            rd_en,
  output logic            alu_en,
  output logic            wr_en,
  output logic [1:0]      op,
  output logic [1:0]      src1_addr,
  output logic [1:0]      src2_addr,
  output logic [1:0]      dest_addr,
  output logic            busy,
  output logic            done,
  output logic [7:0]      retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_READ   = 3'd3,
    S_EXEC   = 3'd4,
    S_WRITE  = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  // Address of the last instruction of a run; pc never moves past it.
  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);
  localparam logic [PC_W-1:0] PC_ZERO = {PC_W{1'b0}};
  localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);

  // State and datapath registers.
  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic [1:0]      op_q, op_d;
  logic [1:0]      src1_q, src1_d;
  logic [1:0]      src2_q, src2_d;
  logic [1:0]      dest_q, dest_d;
  logic [7:0]      retired_q, retired_d;

  // Output flops, loaded from the decode of the next state.
  logic            inst_req_q, inst_req_d;
  logic            rd_en_q, rd_en_d;
  logic            alu_en_q, alu_en_d;
  logic            wr_en_q, wr_en_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Next-state and datapath update: each state holds everything unless it owns a change.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    op_d      = op_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    dest_d    = dest_q;
    retired_d = retired_q;

    case (state_q)
      // IDLE and HALT restart identically; start is only looked at here,
      // so it is ignored for the whole duration of a run.
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d      = PC_ZERO;
          retired_d = 8'd0;
          state_d   = S_FETCH;
        end else begin
          state_d   = state_q;
        end
      end

      // Wait (without bound) for the instruction memory.
      S_FETCH: begin
        if (inst_valid) begin
          ir_d    = inst;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end

      // Split the IR into fields; they stay put until the next DECODE.
      S_DECODE: begin
        op_d    = ir_q[7:6];
        src1_d  = ir_q[5:4];
        src2_d  = ir_q[3:2];
        dest_d  = ir_q[1:0];
        state_d = S_READ;
      end

      S_READ: begin
        state_d = S_EXEC;
      end

      S_EXEC: begin
        state_d = S_WRITE;
      end

      // Hold the write request until the result memory takes it.
      S_WRITE: begin
        if (wr_ready) begin
          retired_d = retired_q + 8'd1;
          if (pc_q == LAST_PC) begin
            state_d = S_HALT;
          end else begin
            pc_d    = pc_q + PC_ONE;
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_WRITE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore output decode of the next state; the strobes are one-hot by construction.
  always_comb begin
    inst_req_d = 1'b0;
    rd_en_d    = 1'b0;
    alu_en_d   = 1'b0;
    wr_en_d    = 1'b0;
    busy_d     = 1'b1;
    done_d     = 1'b0;

    case (state_d)
      S_IDLE: begin
        busy_d = 1'b0;
      end
      S_FETCH: begin
        inst_req_d = 1'b1;
      end
      S_DECODE: begin
        busy_d = 1'b1;
      end
      S_READ: begin
        rd_en_d = 1'b1;
      end
      S_EXEC: begin
        alu_en_d = 1'b1;
      end
      S_WRITE: begin
        wr_en_d = 1'b1;
      end
      S_HALT: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= PC_ZERO;
      ir_q       <= 8'd0;
      op_q       <= 2'd0;
      src1_q     <= 2'd0;
      src2_q     <= 2'd0;
      dest_q     <= 2'd0;
      retired_q  <= 8'd0;
      inst_req_q <= 1'b0;
      rd_en_q    <= 1'b0;
      alu_en_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      op_q       <= op_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      dest_q     <= dest_d;
      retired_q  <= retired_d;
      inst_req_q <= inst_req_d;
      rd_en_q    <= rd_en_d;
      alu_en_q   <= alu_en_d;
      wr_en_q    <= wr_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign pc        = pc_q;
  assign inst_req  = inst_req_q;
  assign rd_en     = rd_en_q;
  assign alu_en    = alu_en_q;
  assign wr_en     = wr_en_q;
  assign op        = op_q;
  assign src1_addr = src1_q;
  assign src2_addr = src2_q;
  assign dest_addr = dest_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign retired   = retired_q;

endmodule
